// File: rtl/sha256_pad.sv
// Collects a byte stream into one FIPS 180-4 padded 512-bit SHA-256 block and holds it until acknowledged.
// Optional build macro LINE_TERM_EN: a CR (0x0D) or LF (0x0A) byte ends the message and is not stored.
module sha256_pad #(
    parameter int MAX_LEN = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:511] blk,
    output logic         blk_valid,
    input  logic         blk_ack,
    output logic [5:0]   len_bytes,
    output logic         ovf
);

    generate
        if (MAX_LEN < 1 || MAX_LEN > 55) begin : g_bad_max_len
            $error("sha256_pad: MAX_LEN must be within 1..55");
        end
    endgenerate

    localparam logic [5:0] MAX_L = 6'(MAX_LEN);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_PAD     = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [0:511]   r_blk;
    logic [5:0]     r_len;
    logic           r_ovf;
    logic           w_accept;
    logic           w_room;
    logic           w_term;
    logic [8:0]     w_bitpos;

`ifdef LINE_TERM_EN
    assign w_term = (in_data == 8'h0D) || (in_data == 8'h0A);
`else
    assign w_term = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == S_COLLECT);
    assign w_room   = (r_len < MAX_L);
    // Bit offset of the next free byte; also equals the message bit length.
    assign w_bitpos = {r_len, 3'b000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        case (r_state)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || w_term)) begin
                    w_next = S_PAD;
                end
            end
            S_PAD: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                blk_valid = 1'b1;
                if (blk_ack) begin
                    w_next = S_COLLECT;
                end
            end
            default: begin
                w_next = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    // Terminator bytes are consumed without touching the block or counters.
                    if (w_accept && !w_term) begin
                        if (w_room) begin
                            r_blk[w_bitpos +: 8] <= in_data;
                            r_len                <= r_len + 6'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    r_blk[w_bitpos +: 8] <= 8'h80;
                    r_blk[448:511]       <= {55'b0, w_bitpos};
                end
                S_HOLD: begin
                    if (blk_ack) begin
                        r_blk <= '0;
                        r_len <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign blk       = r_blk;
    assign len_bytes = r_len;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sha256_pad.sv
// Directed bench for sha256_pad: a queue-based padding model plus literal expectations for known blocks.
// Exercises the LINE_TERM_EN cases when that macro is defined for the build.
module tb_sha256_pad;

    localparam int MAXL = 55;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [0:511] blk;
    logic         blk_valid;
    logic         blk_ack;
    logic [5:0]   len_bytes;
    logic         ovf;

    sha256_pad #(.MAX_LEN(MAXL)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk       (blk),
        .blk_valid (blk_valid),
        .blk_ack   (blk_ack),
        .len_bytes (len_bytes),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: bytes of the current message that the DUT accepted as data.
    byte unsigned mdl_q[$];
    byte unsigned stim[$];
    logic [0:511] mdl_blk;
    logic [5:0]   mdl_len;
    logic         mdl_ovf;
    bit           mdl_armed = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build_expect();
        int n;
        int kept;
        n       = mdl_q.size();
        kept    = (n > MAXL) ? MAXL : n;
        mdl_blk = '0;
        for (int i = 0; i < kept; i++) mdl_blk[i*8 +: 8] = mdl_q[i];
        mdl_blk[kept*8 +: 8] = 8'h80;
        mdl_blk[448 +: 64]   = 64'(kept * 8);
        mdl_len = 6'(kept);
        mdl_ovf = (n > MAXL);
    endfunction

    // Every cycle a block is presented it must match the model's block for the message just sent.
    always @(negedge clk) begin
        if (!reset) begin
            if (blk_valid) begin
                chk("valid_unexpected", 512'(mdl_armed), 512'd1);
                if (mdl_armed) begin
                    chk("blk", blk, mdl_blk);
                    chk("len_bytes", 512'(len_bytes), 512'(mdl_len));
                    chk("ovf", 512'(ovf), 512'(mdl_ovf));
                end
            end
            chk("ready_while_valid", 512'(in_ready & blk_valid), 512'd0);
        end
    end

    // Offer one byte; called and returns at 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input logic last, output bit done);
        bit rdy;
        bit acc;
        bit term;
        acc      = 0;
        term     = 0;
        done     = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        for (int k = 0; k < 50 && !acc; k++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            acc = rdy;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 512'd0, 512'd1);
        end else begin
`ifdef LINE_TERM_EN
            if (b == 8'h0D || b == 8'h0A) term = 1;
`endif
            if (!term) mdl_q.push_back(b);
            done = last || term;
        end
    endtask

    // Send stim[]; if the last byte is a terminator pass last_flag=0.
    task automatic send_seq(input bit last_flag);
        bit done;
        done = 0;
        for (int i = 0; i < stim.size(); i++) begin
            send(8'(stim[i]), (i == stim.size() - 1) ? last_flag : 1'b0, done);
        end
        if (done) begin
            build_expect();
            chk("pad_cycle_valid", 512'(blk_valid), 512'd0);
            mdl_armed = 1;
            @(posedge clk);
            #1;
            chk("latency_valid", 512'(blk_valid), 512'd1);
        end else begin
            chk("msg_not_ended", 512'd0, 512'd1);
        end
    endtask

    task automatic ack();
        blk_ack = 1'b1;
        @(posedge clk);
        #1;
        blk_ack   = 1'b0;
        mdl_armed = 0;
        mdl_q.delete();
        chk("ack_valid", 512'(blk_valid), 512'd0);
        chk("ack_blk", blk, 512'd0);
        chk("ack_len", 512'(len_bytes), 512'd0);
        chk("ack_ovf", 512'(ovf), 512'd0);
        chk("ack_ready", 512'(in_ready), 512'd1);
    endtask

    task automatic set_abc();
        stim.delete();
        stim.push_back(8'h61);
        stim.push_back(8'h62);
        stim.push_back(8'h63);
    endtask

    task automatic set_a(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'h41);
    endtask

    logic [0:511] blk55;
    bit           dummy;

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        in_last  = 1'b0;
        blk_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blk", blk, 512'd0);
        chk("rst_valid", 512'(blk_valid), 512'd0);
        reset = 1'b0;
        chk("rst_ready", 512'(in_ready), 512'd1);
        chk("rst_len", 512'(len_bytes), 512'd0);
        chk("rst_ovf", 512'(ovf), 512'd0);

        // "abc"
        set_abc();
        send_seq(1'b1);
        chk("abc_model_head", 512'(mdl_blk[0:31]), 512'h61626380);
        chk("abc_head", 512'(blk[0:31]), 512'h61626380);
        chk("abc_lenfield", 512'(blk[448:511]), 512'h18);
        chk("abc_len", 512'(len_bytes), 512'd3);
        chk("abc_ovf", 512'(ovf), 512'd0);
        ack();

        // 55 bytes fills the block exactly
        set_a(55);
        send_seq(1'b1);
        chk("a55_marker", 512'(blk[440:447]), 512'h80);
        chk("a55_lenfield", 512'(blk[448:511]), 512'h1B8);
        chk("a55_model_lenfield", 512'(mdl_blk[448:511]), 512'h1B8);
        chk("a55_ovf", 512'(ovf), 512'd0);
        blk55 = blk;
        ack();
        set_abc();
        send_seq(1'b1);
        chk("abc2_residue", 512'(blk[32:447]), 512'd0);
        chk("abc2_head", 512'(blk[0:31]), 512'h61626380);
        ack();

        // 60 bytes truncates to 55
        set_a(60);
        send_seq(1'b1);
        chk("a60_blk", blk, blk55);
        chk("a60_len", 512'(len_bytes), 512'd55);
        chk("a60_ovf", 512'(ovf), 512'd1);
        ack();

        // Backpressure during HOLD, then ack together with a valid byte
        set_abc();
        send_seq(1'b1);
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'(8'h50 + i);
            in_valid = 1'b1;
            chk("bp_ready", 512'(in_ready), 512'd0);
            @(posedge clk);
            #1;
        end
        in_data  = 8'h77;
        in_valid = 1'b1;
        chk("bp_ready_ack", 512'(in_ready), 512'd0);
        ack();
        send(8'h78, 1'b1, dummy);
        chk("bp_resume_len", 512'(len_bytes), 512'd1);
        build_expect();
        mdl_armed = 1;
        @(posedge clk);
        #1;
        chk("bp_resume_blk", 512'(blk[0:15]), 512'h7880);
        ack();

        // Asynchronous reset mid-collect
        set_abc();
        send(8'h61, 1'b0, dummy);
        send(8'h62, 1'b0, dummy);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_blk", blk, 512'd0);
        chk("arst_len", 512'(len_bytes), 512'd0);
        chk("arst_valid", 512'(blk_valid), 512'd0);
        mdl_q.delete();
        mdl_armed = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_abc();
        send_seq(1'b1);
        chk("arst_abc_head", 512'(blk[0:31]), 512'h61626380);
        ack();

`ifdef LINE_TERM_EN
        set_abc();
        stim.push_back(8'h0D);
        send_seq(1'b0);
        chk("cr_head", 512'(blk[0:31]), 512'h61626380);
        chk("cr_len", 512'(len_bytes), 512'd3);
        ack();
        stim.delete();
        stim.push_back(8'h0A);
        send_seq(1'b0);
        chk("empty_blk", blk, {8'h80, 504'd0});
        chk("empty_len", 512'(len_bytes), 512'd0);
        ack();
`else
        stim.delete();
        stim.push_back(8'h61);
        stim.push_back(8'h0D);
        send_seq(1'b1);
        chk("cr_data_head", 512'(blk[0:23]), 512'h610D80);
        chk("cr_data_len", 512'(len_bytes), 512'd2);
        ack();
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
